// File: rtl/load_store_unit.sv
// Memory-stage load/store controller in front of data_mem: one request at a time, single-cycle response.
// Define LSU_MISALIGN_EN to split misaligned accesses; otherwise misaligned requests return an error.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [2:0]  mem_funct3,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

`ifdef LSU_MISALIGN_EN
    typedef enum logic [2:0] {IDLE, ACC0, ACC1, STB, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, ACC0, RESP} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, lo_q;
    logic [2:0]  funct3_q;
    logic        is_store_q, err_q;
    logic        req_legal, req_misaligned, req_err;
    logic [31:0] load_result;

    // Handshake: a request transfers on a rising edge where req_valid and req_ready are both high;
    // the response is a one-cycle resp_valid pulse with no backpressure.
    always_comb begin
        case (req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !req_is_store;
            default:                req_legal = 1'b0;
        endcase
        req_misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                         (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`ifdef LSU_MISALIGN_EN
        req_err = !req_legal;
`else
        req_err = !req_legal || req_misaligned;
`endif
    end

`ifdef LSU_MISALIGN_EN
    logic [31:0] hi_q;
    logic [1:0]  k_q;
    logic [3:0]  size_bytes;
    logic        crossing;
    logic [1:0]  last_k;
    logic [63:0] shifted;

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   size_bytes = 4'd1;
            2'b01:   size_bytes = 4'd2;
            default: size_bytes = 4'd4;
        endcase
        crossing = ({2'b00, addr_q[1:0]} + size_bytes) > 4'd4;
        last_k   = size_bytes[1:0] - 2'd1;
        shifted  = {hi_q, lo_q} >> {addr_q[1:0], 3'b000};
    end
`else
    logic [31:0] shifted;
    always_comb shifted = lo_q >> {addr_q[1:0], 3'b000};
`endif

    always_comb begin
        case (funct3_q)
            3'b000:  load_result = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_result = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_result = {24'h0, shifted[7:0]};
            3'b101:  load_result = {16'h0, shifted[15:0]};
            default: load_result = shifted[31:0];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            lo_q       <= 32'h0;
            funct3_q   <= 3'b000;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
`ifdef LSU_MISALIGN_EN
            hi_q       <= 32'h0;
            k_q        <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                funct3_q   <= req_funct3;
                is_store_q <= req_is_store;
                err_q      <= req_err;
            end
            if (state_q == ACC0 && !is_store_q)
                lo_q <= mem_read_data;
`ifdef LSU_MISALIGN_EN
            if (state_q == ACC1)
                hi_q <= mem_read_data;
            if (state_q == STB)
                k_q <= k_q + 2'd1;
            else
                k_q <= 2'd0;
`endif
        end
    end

    always_comb begin
        state_d          = state_q;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        resp_err         = 1'b0;
        resp_data        = 32'h0;
        mem_address      = 32'h0;
        mem_write_data   = 32'h0;
        mem_funct3       = 3'b000;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        state_d = RESP;
                    end else begin
                        state_d = ACC0;
`ifdef LSU_MISALIGN_EN
                        if (req_is_store && req_misaligned) state_d = STB;
`endif
                    end
                end
            end
            ACC0: begin
                state_d = RESP;
                if (is_store_q) begin
                    mem_write_enable = 1'b1;
                    mem_funct3       = funct3_q;
                    mem_address      = addr_q;
                    mem_write_data   = wdata_q;
                end else begin
                    mem_read_enable = 1'b1;
                    mem_funct3      = 3'b010;
                    mem_address     = {addr_q[31:2], 2'b00};
`ifdef LSU_MISALIGN_EN
                    if (crossing) state_d = ACC1;
`endif
                end
            end
`ifdef LSU_MISALIGN_EN
            ACC1: begin
                state_d         = RESP;
                mem_read_enable = 1'b1;
                mem_funct3      = 3'b010;
                mem_address     = {addr_q[31:2], 2'b00} + 32'd4;
            end
            STB: begin
                mem_write_enable = 1'b1;
                mem_address      = addr_q + {30'h0, k_q};
                mem_write_data   = {24'h0, wdata_q[{k_q, 3'b000} +: 8]};
                if (k_q == last_k) state_d = RESP;
            end
`endif
            RESP: begin
                state_d    = IDLE;
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_data  = (err_q || is_store_q) ? 32'h0 : load_result;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage controller between the pipeline's memory stage and `data_mem`. It accepts one load/store request at a time and computes every address, lane and enable driven into `data_mem`. It performs all load byte/halfword extraction and sign/zero extension itself, and optionally splits misaligned accesses into legal `data_mem` operations. It returns a single-cycle response with the load result or an error flag.

## Interface
- No parameters.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: LSU can accept a request (high only in IDLE).
- `req_is_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: instruction[14:12].
- `req_addr` in 32: effective byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_data` out 32: extended load result; 0 for stores and errors.
- `resp_err` out 1: illegal funct3 or rejected misaligned access; valid with `resp_valid`.
- `mem_address` out 32: to `data_mem.address`.
- `mem_write_data` out 32: to `data_mem.write_data`.
- `mem_funct3` out 3: to `data_mem.funct3`.
- `mem_read_enable` out 1: to `data_mem.read_enable`.
- `mem_write_enable` out 1: to `data_mem.write_enable`.
- `mem_read_data` in 32: from `data_mem.read_data`. Combinational; high-Z when not enabled.

## Operation
- Size is from funct3: 000/100 = 1 byte, 001/101 = 2 bytes, 010 = 4 bytes. Signed loads use 000/001.
- Legal load funct3: 000, 001, 010, 100, 101. Legal store funct3: 000, 001, 010. Anything else is an error.
- Let o = `req_addr[1:0]`.
  - Misaligned: size 2 with o[0] = 1, or size 4 with o != 0.
  - Crossing: o + size > 4.
- FSM states: IDLE, ACC0, ACC1, STB, RESP.
- IDLE: `req_ready` = 1. On `req_valid`, latch addr, wdata, funct3 and is_store.
  - If the request is an error, go to RESP with err = 1.
  - Otherwise go to ACC0 (load or aligned store) or STB (misaligned store).
- ACC0, load:
  - Drive `mem_read_enable` = 1, `mem_funct3` = 010, `mem_address` = {addr[31:2], 2'b00}.
  - Capture `mem_read_data` into the lo register at the clock edge.
  - Go to ACC1 if crossing, else RESP.
- ACC0, aligned store:
  - Drive `mem_write_enable` = 1, `mem_funct3` = latched funct3, `mem_address` = addr, `mem_write_data` = wdata.
  - Go to RESP.
- ACC1: load word at {addr[31:2], 2'b00} + 4 (32-bit modulo, wraps at 0xFFFFFFFC → 0). Capture into the hi register, then go to RESP.
- STB: byte counter k from 0 to size-1, one byte per cycle.
  - Drive `mem_funct3` = 000, `mem_address` = addr + k, `mem_write_data` = {24'b0, wdata[8k+7:8k]}, `mem_write_enable` = 1.
  - After the last byte, go to RESP.
- Load result: form {hi, lo} (64-bit) and shift right by 8·o. Take the low `size` bytes, then sign- or zero-extend per funct3.
- RESP: `resp_valid` = 1 for exactly one cycle, then IDLE. There is no response backpressure.

## Timing
- Reset values: `req_ready` = 1 (IDLE), `resp_valid` = 0, `resp_err` = 0, `resp_data` = 0. All `mem_*` outputs are 0; latched registers are 0.
- All `mem_*` outputs are 0 in IDLE and RESP. Enables are asserted only in ACC0/ACC1/STB.
- Request accepted at edge E:
  - Aligned access: `resp_valid` high in cycle E+2.
  - Crossing load: E+3.
  - Misaligned store of n bytes: E+n+1.
  - Error: E+1.
- `req_ready` is low from E+1 until the cycle after RESP. The earliest back-to-back accept is the RESP cycle +1.
- Stores commit in `data_mem` at the edge that ends ACC0 or each STB cycle.
- Reset mid-operation returns the FSM to IDLE immediately. Bytes already written by STB are not rolled back, and no response is issued.

## Configuration
- `LSU_MISALIGN_EN` defined: misaligned accesses are handled as described above. They are never errors.
- Undefined:
  - Any misaligned access is an error: goes IDLE → RESP with `resp_err` = 1 and `resp_data` = 0.
  - No `mem_*` enable is asserted.
  - The ACC1 and STB states and the hi register are not built.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → `resp_data` = 0xDEADBEEF, err 0, `resp_valid` exactly 2 cycles after accept.
- After the above: LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD; LHU @0x10 → 0x0000BEEF.
- With EN:
  - SW 0x11223344 @0x21 → 4 consecutive SB cycles at 0x21–0x24 with data 0x44, 0x33, 0x22, 0x11; `resp_valid` at E+5.
  - Then LW @0x21 → 0x11223344 at E+3. LW @0x20 → 0x22334400 (low byte 0 from reset).
- Without EN: LH @0x23 → `resp_err` = 1, `resp_data` = 0 at E+1; `mem_read_enable` and `mem_write_enable` never asserted.
- Load funct3 = 011 and store funct3 = 100 → `resp_err` = 1 at E+1; no memory enables asserted.
- With EN: assert `reset` during STB after 2 bytes of a misaligned SW @0x31 → same cycle `req_ready` = 1 and all `mem_*` outputs = 0; no `resp_valid`. Bytes 0x31–0x32 keep their written values.
